// File: rtl/mant_align_rshift.sv
// Three-stage 24-bit significand right shifter for exponent alignment.
// Produces guard/round/sticky for the rounder; global-stall valid/ready pipeline.
module mant_align_rshift (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in,
  input  logic [7:0]  nshiftright,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out,
  output logic        guard,
  output logic        round,
  output logic        sticky
);

  logic        stall;
  logic        adv;

  logic        v1_q;
  logic [25:0] ext_q;
  logic [4:0]  amt_q;
  logic [4:0]  amt_d;

  logic        v2_q;
  logic [25:0] p2_q;
  logic [2:0]  amt2_q;
  logic        st2_q;
  logic [25:0] p2_d;
  logic        st2_d;

  logic        v3_q;
  logic [25:0] res_q;
  logic        st3_q;
  logic [25:0] res_d;
  logic        st3_d;

  logic [25:0] s16;
  logic [25:0] s4;
  logic [25:0] s2;

  assign stall    = v3_q & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = ~stall;

  // Anything past 31 already empties a 26-bit datapath, so five bits suffice.
  assign amt_d = (nshiftright > 8'd31) ? 5'd31 : nshiftright[4:0];

  always_comb begin
    s16   = amt_q[4] ? (ext_q >> 16) : ext_q;
    p2_d  = amt_q[3] ? (s16 >> 8) : s16;
    st2_d = (amt_q[4] & (|ext_q[15:0])) | (amt_q[3] & (|s16[7:0]));
  end

  always_comb begin
    s4    = amt2_q[2] ? (p2_q >> 4) : p2_q;
    s2    = amt2_q[1] ? (s4 >> 2) : s4;
    res_d = amt2_q[0] ? (s2 >> 1) : s2;
    st3_d = st2_q
          | (amt2_q[2] & (|p2_q[3:0]))
          | (amt2_q[1] & (|s4[1:0]))
          | (amt2_q[0] & s2[0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      ext_q <= '0;
      amt_q <= '0;
    end else if (adv) begin
      v1_q  <= in_valid & in_ready;
      ext_q <= {in, 2'b00};
      amt_q <= amt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q   <= 1'b0;
      p2_q   <= '0;
      amt2_q <= '0;
      st2_q  <= 1'b0;
    end else if (adv) begin
      v2_q   <= v1_q;
      p2_q   <= p2_d;
      amt2_q <= amt_q[2:0];
      st2_q  <= st2_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_q  <= 1'b0;
      res_q <= '0;
      st3_q <= 1'b0;
    end else if (adv) begin
      v3_q  <= v2_q;
      res_q <= res_d;
      st3_q <= st3_d;
    end
  end

  assign out_valid = v3_q;
  assign out       = res_q[25:2];
  assign guard     = res_q[1];
  assign round     = res_q[0];
  assign sticky    = st3_q;

endmodule

// File: tb/tb_mant_align_rshift.sv
// Self-checking bench for mant_align_rshift: directed shift/clamp cases, latency,
// backpressure, random streams against an arithmetic reference, and mid-stream reset.
module tb_mant_align_rshift;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in;
  logic [7:0]  nshiftright;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out;
  logic        guard;
  logic        round;
  logic        sticky;

  int n_vec = 0;
  int n_bad = 0;
  int n_fire = 0;
  logic [26:0] exp_q[$];

  mant_align_rshift dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in(in), .nshiftright(nshiftright),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .guard(guard), .round(round), .sticky(sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain wide arithmetic on {in,00}; returns {out, guard, round, sticky}.
  function automatic logic [26:0] model(input logic [23:0] d, input logic [7:0] n);
    longint unsigned ext, r, mask;
    int amt;
    amt  = (n > 31) ? 31 : int'(n);
    ext  = longint'(d) * 4;
    r    = ext >> amt;
    mask = (64'd1 << amt) - 64'd1;
    return {r[25:0], ((ext & mask) != 0)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One cycle: set inputs after the falling edge, then account for any output
  // handshake and any input acceptance that will happen at the next rising edge.
  task automatic drive(input logic v, input logic [23:0] d, input logic [7:0] n,
                       input logic ordy, input logic [26:0] e, output logic acc);
    @(negedge clk);
    in_valid    = v;
    in          = d;
    nshiftright = n;
    out_ready   = ordy;
    #1;
    acc = in_valid & in_ready;
    if (out_valid && out_ready) begin
      n_fire++;
      if (exp_q.size() == 0)
        chk("extra_beat", {5'd0, out, guard, round, sticky}, 32'hxxxx_xxxx);
      else
        chk("result", {5'd0, out, guard, round, sticky}, {5'd0, exp_q.pop_front()});
    end
    if (acc) exp_q.push_back(e);
  endtask

  task automatic idle(input int cycles);
    logic a;
    for (int i = 0; i < cycles; i++) drive(1'b0, 24'd0, 8'd0, 1'b1, 27'd0, a);
  endtask

  typedef struct { logic [23:0] d; logic [7:0] n; logic [26:0] e; } vec_t;
  vec_t dir[$];

  initial begin
    logic acc;
    logic [23:0] d;
    logic [7:0]  n;
    logic        have;
    int          sent, steps, f0;

    rst_n = 1'b0; in_valid = 1'b0; in = '0; nshiftright = '0; out_ready = 1'b0;
    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_data", {5'd0, out, guard, round, sticky}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    dir.push_back('{24'h800000, 8'd1,   {24'h400000, 3'b000}});
    dir.push_back('{24'h800000, 8'd0,   {24'h800000, 3'b000}});
    dir.push_back('{24'h800001, 8'd2,   {24'h200000, 3'b010}});
    dir.push_back('{24'h000003, 8'd3,   {24'h000000, 3'b011}});
    dir.push_back('{24'hFFFFFF, 8'd24,  {24'h000000, 3'b111}});
    dir.push_back('{24'hFFFFFF, 8'd25,  {24'h000000, 3'b011}});
    dir.push_back('{24'hFFFFFF, 8'd26,  {24'h000000, 3'b001}});
    dir.push_back('{24'h0A5001, 8'd31,  {24'h000000, 3'b001}});
    dir.push_back('{24'h000001, 8'd200, {24'h000000, 3'b001}});
    dir.push_back('{24'h000000, 8'd200, {24'h000000, 3'b000}});
    dir.push_back('{24'h123456, 8'd4,   {24'h012345, 3'b011}});

    // Isolated beats: the result shows up on the third edge counting the accepting edge.
    foreach (dir[k]) begin
      drive(1'b1, dir[k].d, dir[k].n, 1'b1, dir[k].e, acc);
      chk("dir_accept", {31'd0, acc}, 32'd1);
      drive(1'b0, 24'd0, 8'd0, 1'b1, 27'd0, acc);
      chk("lat_early1", {31'd0, out_valid}, 32'd0);
      drive(1'b0, 24'd0, 8'd0, 1'b1, 27'd0, acc);
      chk("lat_early2", {31'd0, out_valid}, 32'd0);
      drive(1'b0, 24'd0, 8'd0, 1'b1, 27'd0, acc);
      chk("lat_due", {31'd0, out_valid}, 32'd1);
      idle(1);
    end
    chk("dir_drained", exp_q.size(), 32'd0);

    // Back-to-back random beats at full rate.
    f0 = n_fire;
    for (int i = 0; i < 100; i++) begin
      d = $urandom; n = 8'($urandom_range(0, 40));
      drive(1'b1, d, n, 1'b1, model(d, n), acc);
      if (i >= 3) chk("tput_valid", {31'd0, out_valid}, 32'd1);
    end
    idle(3);
    chk("tput_count", n_fire - f0, 32'd100);
    idle(2);

    // Backpressure: A..D offered while the output is blocked.
    drive(1'b1, 24'hA00001, 8'd1, 1'b0, model(24'hA00001, 8'd1), acc);
    drive(1'b1, 24'hB0000F, 8'd2, 1'b0, model(24'hB0000F, 8'd2), acc);
    drive(1'b1, 24'hC00F00, 8'd9, 1'b0, model(24'hC00F00, 8'd9), acc);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 24'hD12345, 8'd27, 1'b0, model(24'hD12345, 8'd27), acc);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_A", {5'd0, out, guard, round, sticky}, {5'd0, 24'h500000, 3'b100});
    end
    f0 = n_fire;
    drive(1'b1, 24'hD12345, 8'd27, 1'b1, model(24'hD12345, 8'd27), acc);
    chk("bp_D_accept", {31'd0, acc}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 24'd0, 8'd0, 1'b1, 27'd0, acc);
      chk("bp_consec", {31'd0, out_valid}, 32'd1);
    end
    chk("bp_count", n_fire - f0, 32'd4);
    idle(2);

    // Random stream with random backpressure; upstream holds a beat until taken.
    have = 1'b0; sent = 0; steps = 0; f0 = n_fire;
    d = '0; n = '0;
    while (sent < 1000 && steps < 20000) begin
      if (!have && $urandom_range(0, 3) != 0) begin
        d = $urandom;
        n = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 27));
        have = 1'b1;
      end
      drive(have, d, n, ($urandom_range(0, 2) != 0), model(d, n), acc);
      if (acc) begin have = 1'b0; sent++; end
      steps++;
    end
    chk("rand_budget", sent, 32'd1000);
    idle(6);
    chk("rand_count", n_fire - f0, sent);
    chk("rand_drained", exp_q.size(), 32'd0);

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) begin
      d = $urandom; n = 8'($urandom_range(0, 30));
      drive(1'b1, d, n, 1'b1, model(d, n), acc);
    end
    drive(1'b0, 24'd0, 8'd0, 1'b1, 27'd0, acc);
    #1 rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_data", {5'd0, out, guard, round, sticky}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    f0 = n_fire;
    drive(1'b1, 24'h123456, 8'd4, 1'b1, {24'h012345, 3'b011}, acc);
    chk("post_rst_accept", {31'd0, acc}, 32'd1);
    idle(6);
    chk("post_rst_count", n_fire - f0, 32'd1);
    chk("post_rst_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
